// File: rtl/uart1_rx_pkg.sv
// Shared UART1 definitions: receiver state encoding and line levels.
// Imported by the receiver, its synchronizer and the UART1 benches.
package uart1_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    localparam logic UART_IDLE_LVL  = 1'b1;
    localparam logic UART_START_LVL = 1'b0;
    localparam logic UART_STOP_LVL  = 1'b1;

    localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for asynchronous UART line inputs.
// Resets to the idle line level so no false start bit is seen.
module uart_sync2
    import uart1_rx_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= UART_IDLE_LVL;
            q    <= UART_IDLE_LVL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart1_rx.sv
// UART1 receiver: 8N1 framing, mid-bit sampling on an oversampled clock.
// Good frames pulse data_valid; a low stop bit pulses framing_err once.
module uart1_rx
    import uart1_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       framing_err,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);
    localparam logic [2:0]    IDX_LAST = 3'(UART_DATA_BITS - 1);

    logic rx_s;

    rx_state_t state;
    rx_state_t state_n;

    logic [CW-1:0] clk_cnt;
    logic [CW-1:0] cnt_n;
    logic [2:0]    bit_idx;
    logic [2:0]    idx_n;
    logic [7:0]    shift_reg;
    logic [7:0]    shift_n;
    logic [7:0]    dout_n;
    logic          dv_n;
    logic          fe_n;

    uart_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (serial_in),
        .q   (rx_s)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            data_out    <= 8'h00;
            data_valid  <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            state       <= state_n;
            clk_cnt     <= cnt_n;
            bit_idx     <= idx_n;
            shift_reg   <= shift_n;
            data_out    <= dout_n;
            data_valid  <= dv_n;
            framing_err <= fe_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = clk_cnt;
        idx_n   = bit_idx;
        shift_n = shift_reg;
        dout_n  = data_out;
        dv_n    = 1'b0;
        fe_n    = 1'b0;

        unique case (state)
            ST_IDLE: begin
                cnt_n = '0;
                idx_n = '0;
                if (rx_s == UART_START_LVL) begin
                    state_n = ST_START;
                end
            end
            ST_START: begin
                // Re-check mid start bit so short glitches are dropped.
                if (clk_cnt == CNT_HALF) begin
                    cnt_n = '0;
                    if (rx_s == UART_START_LVL) begin
                        state_n = ST_DATA;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    cnt_n = clk_cnt + CW'(1);
                end
            end
            ST_DATA: begin
                if (clk_cnt == CNT_LAST) begin
                    cnt_n   = '0;
                    shift_n = {rx_s, shift_reg[7:1]};
                    idx_n   = bit_idx + 3'd1;
                    if (bit_idx == IDX_LAST) begin
                        state_n = ST_STOP;
                    end
                end else begin
                    cnt_n = clk_cnt + CW'(1);
                end
            end
            ST_STOP: begin
                if (clk_cnt == CNT_LAST) begin
                    cnt_n = '0;
                    if (rx_s == UART_STOP_LVL) begin
                        dout_n  = shift_reg;
                        dv_n    = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        fe_n    = 1'b1;
                        state_n = ST_BREAK;
                    end
                end else begin
                    cnt_n = clk_cnt + CW'(1);
                end
            end
            ST_BREAK: begin
                // Hold here while the line stays low: one error per break.
                cnt_n = '0;
                if (rx_s == UART_IDLE_LVL) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart1_rx.sv
// Directed bench for uart1_rx at CLKS_PER_BIT = 4.
// Table of frames plus hand sequences for glitch, break and reset.
module tb_uart1_rx;

    localparam int C = 4;

    logic       clk;
    logic       rst;
    logic       serial_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       framing_err;
    logic       busy;

    uart1_rx #(.CLKS_PER_BIT(C)) dut (
        .clk         (clk),
        .rst         (rst),
        .serial_in   (serial_in),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .framing_err (framing_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int cyc      = 0;
    int dv_cnt   = 0;
    int fe_cnt   = 0;
    int both_cnt = 0;
    int t_start  = 0;

    int         dv_cyc_q[$];
    logic [7:0] dv_dat_q[$];

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (data_valid) begin
            dv_cnt = dv_cnt + 1;
            dv_cyc_q.push_back(cyc);
            dv_dat_q.push_back(data_out);
        end
        if (framing_err) fe_cnt = fe_cnt + 1;
        if (data_valid && framing_err) both_cnt = both_cnt + 1;
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_dv;
        int         exp_fe;
        logic [7:0] exp_out;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drive_bit(input logic b);
        serial_in = b;
        tick(C);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        t_start = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    task automatic idle(input int n);
        serial_in = 1'b1;
        tick(n);
    endtask

    int dv0;
    int fe0;
    int q0;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
        vecs[1] = '{8'h01, 1'b1, 1, 0, 8'h01};
        vecs[2] = '{8'h80, 1'b1, 1, 0, 8'h80};
        vecs[3] = '{8'h55, 1'b1, 1, 0, 8'h55};
        vecs[4] = '{8'h3C, 1'b0, 0, 1, 8'h55};
        vecs[5] = '{8'hC3, 1'b1, 1, 0, 8'hC3};

        rst       = 1'b0;
        serial_in = 1'b1;
        tick(3);
        check("rst data_out", 32'(data_out), 32'h00);
        check("rst data_valid", 32'(data_valid), 0);
        check("rst framing_err", 32'(framing_err), 0);
        check("rst busy", 32'(busy), 0);
        rst = 1'b1;
        idle(8);

        for (int v = 0; v < 6; v++) begin
            dv0 = dv_cnt;
            fe0 = fe_cnt;
            send_frame(vecs[v].data, vecs[v].stop);
            idle(6);
            check($sformatf("vec%0d valid count", v), dv_cnt - dv0, vecs[v].exp_dv);
            check($sformatf("vec%0d err count", v), fe_cnt - fe0, vecs[v].exp_fe);
            check($sformatf("vec%0d data_out", v), 32'(data_out), 32'(vecs[v].exp_out));
            check($sformatf("vec%0d busy", v), 32'(busy), 0);
            if (vecs[v].exp_dv == 1 && dv_cyc_q.size() > 0)
                check($sformatf("vec%0d latency", v), dv_cyc_q[$] - t_start, 41);
            idle(4);
        end

        q0 = dv_cyc_q.size();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(6);
        check("b2b count", dv_cyc_q.size() - q0, 2);
        if (dv_cyc_q.size() >= q0 + 2) begin
            check("b2b spacing", dv_cyc_q[q0+1] - dv_cyc_q[q0], 40);
            check("b2b first", 32'(dv_dat_q[q0]), 32'h00);
            check("b2b second", 32'(dv_dat_q[q0+1]), 32'hFF);
        end
        idle(4);

        dv0 = dv_cnt;
        fe0 = fe_cnt;
        serial_in = 1'b0;
        tick(1);
        idle(20);
        check("glitch valid", dv_cnt - dv0, 0);
        check("glitch err", fe_cnt - fe0, 0);
        check("glitch data_out", 32'(data_out), 32'hFF);
        check("glitch busy", 32'(busy), 0);

        dv0 = dv_cnt;
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0);
        tick(100);
        check("break err once", fe_cnt - fe0, 1);
        check("break busy held", 32'(busy), 1);
        check("break valid", dv_cnt - dv0, 0);
        check("break data_out", 32'(data_out), 32'hFF);
        idle(6);
        check("break busy released", 32'(busy), 0);
        check("break err total", fe_cnt - fe0, 1);
        idle(4);

        dv0 = dv_cnt;
        fe0 = fe_cnt;
        t_start = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(bit'((8'h5A >> i) & 1));
        serial_in = 1'b0;
        tick(2);
        rst = 1'b0;
        #1;
        check("abort data_out", 32'(data_out), 32'h00);
        check("abort busy", 32'(busy), 0);
        check("abort data_valid", 32'(data_valid), 0);
        serial_in = 1'b1;
        tick(3);
        check("abort no pulses", (dv_cnt - dv0) + (fe_cnt - fe0), 0);
        rst = 1'b1;
        idle(4);
        send_frame(8'h81, 1'b1);
        idle(6);
        check("post reset data_out", 32'(data_out), 32'h81);
        check("post reset valid", dv_cnt - dv0, 1);

        check("valid and err overlap", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
